ub_bank_arbiter: RTL and testbench

- Per-bank access arbiter in front of the unified buffer.
- Accepts one DMA request stream and NB per-bank PE request streams, each a valid/ready handshake.
- Resolves DMA-vs-PE collisions on the same bank, with a starvation guard for DMA.
- Drives the buffer's DMA and PE ports and returns read data with registered response-valid strobes.
- Sits between the DMA engine / compute array and the unified buffer.

---
 rtl/ub_pkg.sv | 30 +++
 rtl/ub_starve_counter.sv | 37 +++
 rtl/ub_bank_arbiter.sv | 158 +++++++++++++++
 tb/tb_ub_bank_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ub_pkg.sv
// ---------------------------------------------------------------------------
// ub_pkg
// Shared definitions for the unified-buffer bank arbiter.
//   UB_DATA_W / UB_ADDR_W : default data / address widths of the buffer
//   bank_w(nb)            : number of bank-select bits for nb banks
//   ub_req_t              : request bundle {we, addr, wdata}
//   bank_of(addr, ...)    : global address -> bank index; the buffer uses the
//                           same decode, so the two must stay in lock-step
// ---------------------------------------------------------------------------
package ub_pkg;

   localparam int UB_DATA_W = 32;
   localparam int UB_ADDR_W = 10;

   function automatic int bank_w(input int nb);
      return $clog2(nb);
   endfunction

   typedef struct packed {
      logic                 we;
      logic [UB_ADDR_W-1:0] addr;
      logic [UB_DATA_W-1:0] wdata;
   } ub_req_t;

   // Bank select is the top bank_w(nb) bits of the global address.
   function automatic int bank_of(input logic [31:0] addr, input int addr_w, input int nb);
      return int'((addr >> (addr_w - bank_w(nb))) & 32'(nb - 1));
   endfunction

endpackage

// File: rtl/ub_starve_counter.sv
// ---------------------------------------------------------------------------
// ub_starve_counter
// Saturating count of consecutive cycles a DMA request has been held off.
//   clk, reset : clock, synchronous active-high reset
//   stall      : DMA request present but not accepted this cycle (count up)
//   xfer       : DMA request accepted this cycle (clear)
//   expired    : count has reached MAX_WAIT; DMA now wins collisions
// With neither stall nor xfer (no DMA request) the count holds.
// ---------------------------------------------------------------------------
module ub_starve_counter #(
   parameter int WAIT_W   = 4,
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic stall,
   input  logic xfer,
   output logic expired
);

   logic [WAIT_W-1:0] wait_cnt;

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge value of its inputs regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (xfer) begin
         wait_cnt <= '0;
      end else if (stall && (wait_cnt != '1)) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   assign expired = (wait_cnt >= WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/ub_bank_arbiter.sv
// ---------------------------------------------------------------------------
// ub_bank_arbiter
// Per-bank arbiter between one DMA request stream and NB per-bank PE request
// streams in front of the unified buffer. On a DMA/PE collision on the same
// bank the PE wins unless cfg_dma_priority is set or the DMA has been held
// off for MAX_WAIT cycles. Reads return one cycle after the grant.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   cfg_dma_priority     : 1 = DMA always wins collisions
//   dma_req_*            : DMA request (valid/ready, we, global addr, wdata)
//   dma_rsp_valid/data   : DMA read response
//   pe_req_*             : NB per-bank PE requests (flattened, bank 0 at LSB)
//   pe_rsp_valid/data    : NB per-bank PE read responses
//   ub_dma_*             : buffer DMA port (enables, global addr, write data)
//   ub_pe_*              : buffer per-bank PE ports
//   ub_pe_data_out       : per-bank registered read data from the buffer
//
// The DMA request is carried internally in ub_req_t, which is sized by the
// package widths; DATA_W / ADDR_W are expected to equal them.
// ---------------------------------------------------------------------------
module ub_bank_arbiter
   import ub_pkg::*;
#(
   parameter int DATA_W   = UB_DATA_W,
   parameter int ADDR_W   = UB_ADDR_W,
   parameter int NB       = 4,
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_dma_priority,

   input  logic                 dma_req_valid,
   output logic                 dma_req_ready,
   input  logic                 dma_req_we,
   input  logic [ADDR_W-1:0]    dma_req_addr,
   input  logic [DATA_W-1:0]    dma_req_wdata,
   output logic                 dma_rsp_valid,
   output logic [DATA_W-1:0]    dma_rsp_data,

   input  logic [NB-1:0]        pe_req_valid,
   output logic [NB-1:0]        pe_req_ready,
   input  logic [NB-1:0]        pe_req_we,
   input  logic [NB*ADDR_W-1:0] pe_req_addr,
   input  logic [NB*DATA_W-1:0] pe_req_wdata,
   output logic [NB-1:0]        pe_rsp_valid,
   output logic [NB*DATA_W-1:0] pe_rsp_data,

   output logic                 ub_dma_write_en,
   output logic                 ub_dma_read_en,
   output logic [ADDR_W-1:0]    ub_dma_addr,
   output logic [DATA_W-1:0]    ub_dma_data_in,
   output logic [NB-1:0]        ub_pe_read_en,
   output logic [NB-1:0]        ub_pe_write_en,
   output logic [NB*ADDR_W-1:0] ub_pe_addr,
   output logic [NB*DATA_W-1:0] ub_pe_data_in,
   input  logic [NB*DATA_W-1:0] ub_pe_data_out
);

   localparam int BANK_W = bank_w(NB);

   ub_req_t             dma_req;
   logic [BANK_W-1:0]   dma_bank;
   logic                dma_collide;
   logic                dma_wins;
   logic                dma_grant;
   logic [NB-1:0]       pe_grant;
   logic                wait_expired;

   logic                rd_dma_q;
   logic [BANK_W-1:0]   dma_bank_q;
   logic [NB-1:0]       rd_pe_q;

   assign dma_req = '{we:    dma_req_we,
                      addr:  UB_ADDR_W'(dma_req_addr),
                      wdata: UB_DATA_W'(dma_req_wdata)};

   // ------------------------------------------------------------------
   // Starvation guard
   // ------------------------------------------------------------------
   ub_starve_counter #(
      .WAIT_W   (WAIT_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk     (clk),
      .reset   (reset),
      .stall   (dma_req_valid & ~dma_grant),
      .xfer    (dma_req_valid & dma_grant),
      .expired (wait_expired)
   );

   // ------------------------------------------------------------------
   // Combinational arbitration. Only the bank addressed by the DMA can
   // collide, so a DMA request never affects PEs on other banks. Grants
   // are forced low during reset so nothing reaches the buffer.
   // ------------------------------------------------------------------
   // NOTE: every signal written here gets a default before any condition,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      dma_bank    = BANK_W'(bank_of(32'(dma_req.addr), ADDR_W, NB));
      dma_collide = dma_req_valid & pe_req_valid[dma_bank];
      dma_wins    = cfg_dma_priority | wait_expired;
      dma_grant   = 1'b0;
      pe_grant    = '0;

      if (!reset) begin
         dma_grant = dma_req_valid & (~dma_collide | dma_wins);
         for (int b = 0; b < NB; b++) begin
            pe_grant[b] = pe_req_valid[b]
                        & ~(dma_collide & dma_wins & (dma_bank == BANK_W'(b)));
         end
      end
   end

   assign dma_req_ready = dma_grant;
   assign pe_req_ready  = pe_grant;

   // ------------------------------------------------------------------
   // Buffer ports: enables follow the grant, addr/data pass through.
   // ------------------------------------------------------------------
   assign ub_dma_write_en = dma_grant &  dma_req.we;
   assign ub_dma_read_en  = dma_grant & ~dma_req.we;
   assign ub_dma_addr     = ADDR_W'(dma_req.addr);
   assign ub_dma_data_in  = DATA_W'(dma_req.wdata);

   assign ub_pe_write_en  = pe_grant &  pe_req_we;
   assign ub_pe_read_en   = pe_grant & ~pe_req_we;
   assign ub_pe_addr      = pe_req_addr;
   assign ub_pe_data_in   = pe_req_wdata;

   // ------------------------------------------------------------------
   // Read response tracking (buffer read latency is one cycle).
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_dma_q   <= 1'b0;
         dma_bank_q <= '0;
         rd_pe_q    <= '0;
      end else begin
         rd_dma_q   <= dma_grant & ~dma_req.we;
         dma_bank_q <= dma_bank;
         rd_pe_q    <= pe_grant & ~pe_req_we;
      end
   end

   // Valids are also masked by reset so a read granted just before reset
   // rises never shows a response.
   assign dma_rsp_valid = rd_dma_q & ~reset;
   assign pe_rsp_valid  = rd_pe_q & {NB{~reset}};

   // A DMA read occupies its bank's read port; that bank's PE was blocked,
   // so its data output carries the DMA word.
   assign dma_rsp_data  = ub_pe_data_out[dma_bank_q*DATA_W +: DATA_W];
   assign pe_rsp_data   = ub_pe_data_out;

endmodule

// File: tb/tb_ub_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ub_bank_arbiter
// Drives directed and random traffic into ub_bank_arbiter, with a small
// unified-buffer model attached to its ub_* ports. A reference model computes
// grants and read data from the arbitration rules and a global memory image;
// expected responses are queued and a negedge monitor compares them.
// ---------------------------------------------------------------------------
module tb_ub_bank_arbiter;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 10;
   localparam int NB       = 4;
   localparam int MAX_WAIT = 4;
   localparam int WAIT_W   = 4;
   localparam int BANK_W   = 2;
   localparam int LOCAL_W  = ADDR_W - BANK_W;
   localparam int DEPTH    = 1 << ADDR_W;
   localparam int LMASK    = (1 << LOCAL_W) - 1;
   localparam int WAIT_SAT = (1 << WAIT_W) - 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 cfg_dma_priority;
   logic                 dma_req_valid;
   logic                 dma_req_ready;
   logic                 dma_req_we;
   logic [ADDR_W-1:0]    dma_req_addr;
   logic [DATA_W-1:0]    dma_req_wdata;
   logic                 dma_rsp_valid;
   logic [DATA_W-1:0]    dma_rsp_data;
   logic [NB-1:0]        pe_req_valid;
   logic [NB-1:0]        pe_req_ready;
   logic [NB-1:0]        pe_req_we;
   logic [NB*ADDR_W-1:0] pe_req_addr;
   logic [NB*DATA_W-1:0] pe_req_wdata;
   logic [NB-1:0]        pe_rsp_valid;
   logic [NB*DATA_W-1:0] pe_rsp_data;
   logic                 ub_dma_write_en;
   logic                 ub_dma_read_en;
   logic [ADDR_W-1:0]    ub_dma_addr;
   logic [DATA_W-1:0]    ub_dma_data_in;
   logic [NB-1:0]        ub_pe_read_en;
   logic [NB-1:0]        ub_pe_write_en;
   logic [NB*ADDR_W-1:0] ub_pe_addr;
   logic [NB*DATA_W-1:0] ub_pe_data_in;
   logic [NB*DATA_W-1:0] ub_pe_data_out;

   always #5 clk = ~clk;

   ub_bank_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NB(NB), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)
   ) dut (
      .clk(clk), .reset(reset), .cfg_dma_priority(cfg_dma_priority),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
      .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
      .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
      .pe_req_valid(pe_req_valid), .pe_req_ready(pe_req_ready), .pe_req_we(pe_req_we),
      .pe_req_addr(pe_req_addr), .pe_req_wdata(pe_req_wdata),
      .pe_rsp_valid(pe_rsp_valid), .pe_rsp_data(pe_rsp_data),
      .ub_dma_write_en(ub_dma_write_en), .ub_dma_read_en(ub_dma_read_en),
      .ub_dma_addr(ub_dma_addr), .ub_dma_data_in(ub_dma_data_in),
      .ub_pe_read_en(ub_pe_read_en), .ub_pe_write_en(ub_pe_write_en),
      .ub_pe_addr(ub_pe_addr), .ub_pe_data_in(ub_pe_data_in),
      .ub_pe_data_out(ub_pe_data_out)
   );

   // ------------------------------------------------------------------
   // Unified buffer model: global array, bank = top address bits, one
   // registered read output per bank shared by the DMA and PE ports.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] buf_mem  [DEPTH];
   logic [DATA_W-1:0] buf_dout [NB];
   int                bm_g, bm_b, bm_pg;

   always @(posedge clk) begin
      bm_g = int'(ub_dma_addr);
      bm_b = bm_g >> LOCAL_W;
      if (ub_dma_write_en) buf_mem[bm_g] <= ub_dma_data_in;
      if (ub_dma_read_en)  buf_dout[bm_b] <= buf_mem[bm_g];
      for (int b = 0; b < NB; b++) begin
         bm_pg = (b << LOCAL_W) | (int'(ub_pe_addr[b*ADDR_W +: ADDR_W]) & LMASK);
         if (ub_pe_write_en[b]) buf_mem[bm_pg] <= ub_pe_data_in[b*DATA_W +: DATA_W];
         if (ub_pe_read_en[b] && !(ub_dma_read_en && bm_b == b))
            buf_dout[b] <= buf_mem[bm_pg];
      end
   end

   always_comb begin
      for (int b = 0; b < NB; b++) ub_pe_data_out[b*DATA_W +: DATA_W] = buf_dout[b];
   end

   // ------------------------------------------------------------------
   // Reference model state and scoreboard
   // ------------------------------------------------------------------
   typedef struct {
      logic [DATA_W-1:0] data;
      int                cyc;
   } exp_t;

   logic [DATA_W-1:0] ref_mem [DEPTH];
   int                m_wait;
   exp_t              dma_q [$];
   exp_t              pe_q  [NB][$];
   int                cyc = 0;
   bit                mon_en = 1'b0;
   int                checks = 0;
   int                failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Evaluate the current inputs against the arbitration rules, check the
   // readies, queue expected read data, update the memory image, advance.
   task automatic cycle();
      int            db, g;
      bit            coll, dwin, e_dr;
      logic [NB-1:0] e_pr;
      #1;
      e_dr = 1'b0;
      e_pr = '0;
      if (reset) begin
         m_wait = 0;
         dma_q.delete();
         for (int b = 0; b < NB; b++) pe_q[b].delete();
      end else begin
         db   = int'(dma_req_addr) >> LOCAL_W;
         coll = dma_req_valid && pe_req_valid[db];
         dwin = cfg_dma_priority || (m_wait >= MAX_WAIT);
         e_dr = dma_req_valid && (!coll || dwin);
         for (int b = 0; b < NB; b++) e_pr[b] = pe_req_valid[b] && !(coll && dwin && b == db);
         if (e_dr)                                   m_wait = 0;
         else if (dma_req_valid && m_wait < WAIT_SAT) m_wait++;
      end
      check("dma_req_ready", 64'(dma_req_ready), 64'(e_dr));
      check("pe_req_ready",  64'(pe_req_ready),  64'(e_pr));
      // Reads see the image before this cycle's writes.
      if (e_dr && !dma_req_we) dma_q.push_back('{ref_mem[int'(dma_req_addr)], cyc + 1});
      for (int b = 0; b < NB; b++) begin
         g = (b << LOCAL_W) | (int'(pe_req_addr[b*ADDR_W +: ADDR_W]) & LMASK);
         if (e_pr[b] && !pe_req_we[b]) pe_q[b].push_back('{ref_mem[g], cyc + 1});
      end
      if (e_dr && dma_req_we) ref_mem[int'(dma_req_addr)] = dma_req_wdata;
      for (int b = 0; b < NB; b++) begin
         g = (b << LOCAL_W) | (int'(pe_req_addr[b*ADDR_W +: ADDR_W]) & LMASK);
         if (e_pr[b] && pe_req_we[b]) ref_mem[g] = pe_req_wdata[b*DATA_W +: DATA_W];
      end
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Monitor: each response stream must be valid exactly in the cycle its
   // oldest expectation is due, carrying that data.
   // ------------------------------------------------------------------
   exp_t mon_e;
   bit   mon_v;

   always @(negedge clk) begin
      if (mon_en) begin
         mon_v = (dma_q.size() > 0) && (dma_q[0].cyc == cyc);
         check("dma_rsp_valid", 64'(dma_rsp_valid), 64'(mon_v));
         if (mon_v) begin
            mon_e = dma_q.pop_front();
            if (dma_rsp_valid) check("dma_rsp_data", 64'(dma_rsp_data), 64'(mon_e.data));
         end
         for (int b = 0; b < NB; b++) begin
            mon_v = (pe_q[b].size() > 0) && (pe_q[b][0].cyc == cyc);
            check($sformatf("pe%0d_rsp_valid", b), 64'(pe_rsp_valid[b]), 64'(mon_v));
            if (mon_v) begin
               mon_e = pe_q[b].pop_front();
               if (pe_rsp_valid[b])
                  check($sformatf("pe%0d_rsp_data", b), 64'(pe_rsp_data[b*DATA_W +: DATA_W]),
                        64'(mon_e.data));
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic idle();
      cfg_dma_priority = 1'b0;
      dma_req_valid    = 1'b0;
      dma_req_we       = 1'b0;
      dma_req_addr     = '0;
      dma_req_wdata    = '0;
      pe_req_valid     = '0;
      pe_req_we        = '0;
      pe_req_addr      = '0;
      pe_req_wdata     = '0;
   endtask

   task automatic set_dma(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      dma_req_valid = 1'b1;
      dma_req_we    = we;
      dma_req_addr  = a;
      dma_req_wdata = d;
   endtask

   task automatic set_pe(input int b, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      pe_req_valid[b]                  = 1'b1;
      pe_req_we[b]                     = we;
      pe_req_addr[b*ADDR_W +: ADDR_W]  = a;
      pe_req_wdata[b*DATA_W +: DATA_W] = d;
   endtask

   initial begin
      for (int g = 0; g < DEPTH; g++) begin
         buf_mem[g] = 32'hC0DE_0000 + DATA_W'(g);
         ref_mem[g] = 32'hC0DE_0000 + DATA_W'(g);
      end
      for (int b = 0; b < NB; b++) buf_dout[b] = '0;
      m_wait = 0;
      reset  = 1'b1;
      idle();
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Reset with requests present: nothing may be granted.
      set_dma(1'b0, 10'h000, '0);
      set_pe(1, 1'b0, 10'h001, '0);
      cycle();
      cycle();
      reset = 1'b0;
      idle();
      cycle();

      // 1: no conflict, DMA read bank 0 and PE[2] write.
      set_dma(1'b0, 10'h000, '0);
      set_pe(2, 1'b1, 10'h005, 32'h0000_DEAD);
      #1;
      check("t1_both_ready", 64'({dma_req_ready, pe_req_ready[2]}), 64'(2'b11));
      cycle();
      idle();
      cycle();

      // 2: collision on bank 1, PE priority; DMA wins on the fifth cycle.
      for (int i = 0; i < 6; i++) begin
         set_dma(1'b0, 10'h100, '0);
         set_pe(1, 1'b0, 10'h003, '0);
         #1;
         check("t2_dma_ready", 64'(dma_req_ready), 64'(i == 4));
         check("t2_pe1_ready", 64'(pe_req_ready[1]), 64'(i != 4));
         cycle();
      end
      idle();
      set_dma(1'b0, 10'h010, '0);   // uncontested transfer clears the count
      cycle();
      idle();
      cycle();

      // 3: DMA priority on bank 3, then PE priority again to confirm the
      // count did not move (PE wins four cycles, DMA the fifth).
      cfg_dma_priority = 1'b1;
      set_dma(1'b0, 10'h3F0, '0);
      set_pe(3, 1'b0, 10'h020, '0);
      #1;
      check("t3_dma_ready", 64'({dma_req_ready, pe_req_ready[3]}), 64'(2'b10));
      cycle();
      cfg_dma_priority = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t3_count_zero", 64'(dma_req_ready), 64'(i == 4));
         cycle();
      end
      idle();
      cycle();

      // 4: DMA write then read of the same word.
      set_dma(1'b1, 10'h101, 32'h1234_5678);
      cycle();
      set_dma(1'b0, 10'h101, '0);
      cycle();
      idle();
      cycle();

      // 5: PE[0] streams reads of local addresses 0..7.
      for (int i = 0; i < 8; i++) begin
         set_pe(0, 1'b0, ADDR_W'(i), '0);
         cycle();
      end
      idle();
      cycle();

      // 6: stall the DMA, grant a read, then reset the next cycle.
      set_dma(1'b0, 10'h200, '0);
      set_pe(2, 1'b0, 10'h007, '0);
      cycle();
      cycle();
      idle();
      set_dma(1'b0, 10'h040, '0);
      cycle();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_dma(1'b0, 10'h200, '0);
         set_pe(2, 1'b0, 10'h007, '0);
         #1;
         check("t6_count_cleared", 64'(dma_req_ready), 64'(i == 4));
         cycle();
      end
      idle();
      cycle();

      // Random traffic, biased toward collisions on the DMA's bank.
      for (int n = 0; n < 800; n++) begin
         idle();
         reset            = ($urandom_range(0, 99) == 0);
         cfg_dma_priority = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) != 0)
            set_dma(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 2) != 0 ||
                (dma_req_valid && (int'(dma_req_addr) >> LOCAL_W) == b))
               set_pe(b, 1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom);
         end
         cycle();
      end
      reset = 1'b0;
      idle();
      for (int i = 0; i < 4; i++) cycle();

      check("dma_q_drained", 64'(dma_q.size()), 64'(0));
      for (int b = 0; b < NB; b++)
         check($sformatf("pe%0d_q_drained", b), 64'(pe_q[b].size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
